// File: rtl/dbuf_serial_lut.sv
// ---------------------------------------------------------------------------
// dbuf_serial_lut
//
// Double-buffered, bit-serially loaded lookup table. A new table is shifted
// into a shadow register while the active table keeps serving lookups. A
// commit strobe swaps the complete shadow into the active table in one edge.
// The active table can also be rotated by ROT_LEN bits.
//
// Entry i of either table occupies bits [(i+1)*OUT_WIDTH-1 -: OUT_WIDTH].
// The first bit shifted ends up in the MSB after TABLE_BITS shifts.
//
// Build option:
//   LUT_READBACK_EN - when defined, dout is the shadow MSB, so shifting
//                     TABLE_BITS further bits reads out the previous shadow
//                     MSB-first (also allows chaining d->dout). When not
//                     defined, dout is tied low.
//
// Ports:
//   clk     in   1          rising-edge clock
//   rst     in   1          asynchronous active-high reset
//   d       in   1          serial load data
//   cs_n    in   1          active-low shift enable for the shadow register
//   commit  in   1          copy shadow to active when the shadow is full
//   rot_n   in   1          active-low rotate of the active table
//   sel     in   IN_WIDTH   lookup index
//   out     out  OUT_WIDTH  registered lookup result (1-cycle latency)
//   full    out  1          shadow holds a complete table
//   err     out  1          sticky: commit requested while not full
//   dout    out  1          serial readback (see build option)
// ---------------------------------------------------------------------------
module dbuf_serial_lut #(
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 8,
  parameter int ROT_LEN   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 d,
  input  logic                 cs_n,
  input  logic                 commit,
  input  logic                 rot_n,
  input  logic [IN_WIDTH-1:0]  sel,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 full,
  output logic                 err,
  output logic                 dout
);

  localparam int ENTRIES    = 2 ** IN_WIDTH;
  localparam int TABLE_BITS = ENTRIES * OUT_WIDTH;
  localparam int CNT_W      = $clog2(TABLE_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TABLE_BITS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [TABLE_BITS-1:0]  shadow_q, shadow_d;
  logic [TABLE_BITS-1:0]  active_q, active_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   full_q, full_d;
  logic                   err_q, err_d;
  logic [OUT_WIDTH-1:0]   out_q, out_d;
  logic                   commit_ok_s;
  logic [OUT_WIDTH-1:0]   entry_s [ENTRIES];

  // Slice the active table into its entries for the lookup mux.
  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    assign entry_s[g] = active_q[g*OUT_WIDTH +: OUT_WIDTH];
  end

  // Shadow shift path; runs in every state, including past saturation.
  always_comb begin
    shadow_d = shadow_q;
    if (!cs_n) begin
      shadow_d = {shadow_q[TABLE_BITS-2:0], d};
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Load FSM: bit counter, full flag, commit acceptance and sticky error.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    full_d      = full_q;
    err_d       = err_q;
    commit_ok_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOADING: begin
        if (!cs_n) begin
          count_d = count_q + CNT_ONE;
          if (count_d == CNT_FULL) begin
            // full rises on the same edge the last bit lands
            state_d = ST_FULL;
            full_d  = 1'b1;
          end else begin
            state_d = ST_LOADING;
          end
        end else begin
          state_d = state_q;
        end
        if (commit) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end
      ST_FULL: begin
        if (commit) begin
          // commit takes the pre-shift shadow; a simultaneous shift starts
          // the next load
          commit_ok_s = 1'b1;
          err_d       = 1'b0;
          full_d      = 1'b0;
          if (!cs_n) begin
            count_d = CNT_ONE;
            state_d = ST_LOADING;
          end else begin
            count_d = CNT_ZERO;
            state_d = ST_IDLE;
          end
        end else begin
          // extra shifts drop the oldest bits; count stays saturated
          count_d = count_q;
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = CNT_ZERO;
        full_d  = 1'b0;
      end
    endcase
  end

  // Active table update: commit beats rotate; any commit request blocks rotate.
  always_comb begin
    active_d = active_q;
    if (commit_ok_s) begin
      active_d = shadow_q;
    end else if (!rot_n && !commit) begin
      active_d = {active_q[ROT_LEN-1:0], active_q[TABLE_BITS-1:ROT_LEN]};
    end else begin
      active_d = active_q;
    end
  end

  // Lookup of the current active table; registered below.
  always_comb begin
    out_d = entry_s[sel];
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      active_q <= '0;
      count_q  <= CNT_ZERO;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      count_q  <= count_d;
      full_q   <= full_d;
      err_q    <= err_d;
      out_q    <= out_d;
    end
  end

  assign out  = out_q;
  assign full = full_q;
  assign err  = err_q;

`ifdef LUT_READBACK_EN
  assign dout = shadow_q[TABLE_BITS-1];
`else
  assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_dbuf_serial_lut.sv
// Self-checking bench for dbuf_serial_lut with default parameters
// (4 entries x 8 bits, rotate by 8). A behavioural table model predicts
// out/full/err/dout every cycle; directed sequences add fixed-value checks.
module tb_dbuf_serial_lut;

  localparam int IW = 2;
  localparam int OW = 8;
  localparam int RL = 8;
  localparam int TB = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          d;
  logic          cs_n;
  logic          commit;
  logic          rot_n;
  logic [IW-1:0] sel;
  logic [OW-1:0] out;
  logic          full;
  logic          err;
  logic          dout;

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model state
  bit [31:0] m_shadow;
  bit [31:0] m_active;
  int        m_count;
  bit        m_err;
  bit [7:0]  m_out;

  bit [31:0] rb_word;

  always #5 clk = ~clk;

  dbuf_serial_lut #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .ROT_LEN(RL)) dut (
    .clk    (clk),
    .rst    (rst),
    .d      (d),
    .cs_n   (cs_n),
    .commit (commit),
    .rot_n  (rot_n),
    .sel    (sel),
    .out    (out),
    .full   (full),
    .err    (err),
    .dout   (dout)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_shadow = 32'd0;
    m_active = 32'd0;
    m_count  = 0;
    m_err    = 1'b0;
    m_out    = 8'd0;
  endtask

  function automatic bit exp_dout();
`ifdef LUT_READBACK_EN
    return m_shadow[31];
`else
    return 1'b0;
`endif
  endfunction

  // One clock edge of the table's behaviour, from the rules in plain arithmetic.
  task automatic model_edge();
    bit [31:0] old_active;
    bit [31:0] sh;
    bit        was_full;
    bit        shift;
    old_active = m_active;
    was_full   = (m_count == TB);
    shift      = !cs_n;
    sh         = old_active >> (8 * int'(sel));
    m_out      = sh[7:0];
    if (commit && was_full) begin
      m_active = m_shadow;
      m_err    = 1'b0;
      m_count  = shift ? 1 : 0;
    end else begin
      if (commit) m_err = 1'b1;
      if (!commit && !rot_n) m_active = (old_active >> RL) | (old_active << (TB - RL));
      if (shift && m_count < TB) m_count = m_count + 1;
    end
    if (shift) m_shadow = (m_shadow << 1) | {31'd0, d};
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("out",  {24'd0, out}, {24'd0, m_out});
    check_eq("full", {31'd0, full}, {31'd0, (m_count == TB)});
    check_eq("err",  {31'd0, err},  {31'd0, m_err});
    check_eq("dout", {31'd0, dout}, {31'd0, exp_dout()});
  endtask

  task automatic cyc(input bit d_i, input bit cs_i, input bit cm_i, input bit rn_i, input bit [1:0] s_i);
    d      = d_i;
    cs_n   = cs_i;
    commit = cm_i;
    rot_n  = rn_i;
    sel    = s_i;
    tick();
  endtask

  // Shift the top nbits of w, MSB first.
  task automatic shift_bits(input bit [31:0] w, input int nbits, input bit [1:0] s_i);
    bit [31:0] v;
    v = w;
    for (int i = 0; i < nbits; i++) begin
      cyc(v[31], 1'b0, 1'b0, 1'b1, s_i);
      v = v << 1;
    end
  endtask

  task automatic load_commit(input bit [31:0] w);
    shift_bits(w, 32, 2'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
  endtask

  initial begin
    rst = 1'b1; d = 1'b0; cs_n = 1'b1; commit = 1'b0; rot_n = 1'b1; sel = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out", {24'd0, out}, 32'h0);
    check_eq("rst_full", {31'd0, full}, 32'h0);
    rst = 1'b0;

    // idle for 10 cycles, sweeping sel
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 2'(i));
      check_eq("idle_out", {24'd0, out}, 32'h0);
    end

    // full load, full flag timing, commit, lookup latency
    shift_bits(32'hA1B2C3D4, 31, 2'd3);
    check_eq("full_31", {31'd0, full}, 32'h0);
    shift_bits(32'h00000000, 0, 2'd3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'd3);  // 32nd bit of 0xA1B2C3D4 is 0
    check_eq("full_32", {31'd0, full}, 32'h1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 2'd3);
    check_eq("full_after_commit", {31'd0, full}, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
    check_eq("commit_sel3", {24'd0, out}, 32'hA1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    check_eq("commit_sel0", {24'd0, out}, 32'hD4);

    // early commit sets err, then a proper commit clears it
    shift_bits(32'h12345678, 16, 2'd3);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 2'd3);
    check_eq("early_err", {31'd0, err}, 32'h1);
    check_eq("early_full", {31'd0, full}, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
    check_eq("early_out_kept", {24'd0, out}, 32'hA1);
    shift_bits(32'h56780000, 16, 2'd3);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 2'd3);
    check_eq("late_err", {31'd0, err}, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
    check_eq("late_out", {24'd0, out}, 32'h12);

    // rotate
    load_commit(32'hA1B2C3D4);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    check_eq("rot_sel0", {24'd0, out}, 32'hC3);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
    check_eq("rot_sel3", {24'd0, out}, 32'hD4);

    // commit and rotate together: commit wins
    shift_bits(32'h11223344, 32, 2'd3);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'd3);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
    check_eq("cmrot_sel3", {24'd0, out}, 32'h11);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    check_eq("cmrot_sel0", {24'd0, out}, 32'h44);

    // active output stable during a partial load, then reset mid-load
    for (int i = 0; i < 20; i++) begin
      cyc(1'($urandom), 1'b0, 1'b0, 1'b1, 2'd3);
      check_eq("load_hold", {24'd0, out}, 32'h11);
    end
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("mid_rst_out", {24'd0, out}, 32'h0);
    check_eq("mid_rst_full", {31'd0, full}, 32'h0);
    check_eq("mid_rst_err", {31'd0, err}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
    check_eq("post_rst_err", {31'd0, err}, 32'h1);

    // serial readback: previous shadow leaves MSB-first
    shift_bits(32'hA1B2C3D4, 32, 2'd0);
    rb_word = {31'd0, dout};
    for (int i = 0; i < 31; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
      rb_word = (rb_word << 1) | {31'd0, dout};
    end
`ifdef LUT_READBACK_EN
    check_eq("readback", rb_word, 32'hA1B2C3D4);
`else
    check_eq("readback", rb_word, 32'h0);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 7) != 0), 2'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
